// File: rtl/asi_wr_if.sv
// AXI write-channel bundle (AW, W, B) shared by the asi_wr slave and its driver.
interface asi_wr_if #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3
) ();
    localparam int AXI_WSTRBW = AXI_DW / 8;

    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [AXI_SW-1:0]     AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_IW-1:0]     BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/asi_wr.sv
// AXI write slave that turns one INCR/FIXED burst at a time into single-beat memory writes.
// state | meaning
// IDLE  | waiting for a write address, AWREADY high
// DATA  | accepting W beats; writes to memory unless the burst is in error (drain)
// RESP  | presenting the B response until BREADY
module asi_wr #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    asi_wr_if.slave                 axi,
    output logic                    mem_we,
    output logic [AXI_AW-1:0]       mem_addr,
    output logic [AXI_DW-1:0]       mem_wdata,
    output logic [AXI_DW/8-1:0]     mem_wstrb,
    input  logic                    mem_ready
);
    localparam int AXI_WSTRBW = AXI_DW / 8;
    localparam int MAX_SIZE   = $clog2(AXI_WSTRBW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, next_state;
    logic [AXI_IW-1:0]   bid_q;
    logic [AXI_AW-1:0]   addr_q;
    logic [AXI_LW-1:0]   len_q;
    logic [AXI_SW-1:0]   size_q;
    logic                incr_q;
    logic [AXI_LW:0]     cnt_q;
    logic                err_q;
    logic [1:0]          bresp_q;

    logic                awready, wready, bvalid;
    logic                aw_hs, beat, last_beat, wlast_bad, bad_aw;
    logic [AXI_AW-1:0]   align_mask, step;

    assign last_beat  = (cnt_q == {1'b0, len_q});
    assign wlast_bad  = (axi.WLAST != last_beat);
    assign aw_hs      = axi.AWVALID & awready;
    assign beat       = axi.WVALID & wready;
    assign align_mask = {AXI_AW{1'b1}} << axi.AWSIZE;
    assign step       = AXI_AW'(1) << size_q;
    // WRAP, the reserved encoding and sizes wider than the bus are refused but still drained
    assign bad_aw     = axi.AWBURST[1] | (axi.AWSIZE > AXI_SW'(MAX_SIZE));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        unique case (state_q)
            IDLE: begin
                awready = 1'b1;
                if (axi.AWVALID) next_state = DATA;
            end
            DATA: begin
                wready = mem_ready | err_q;
                if (axi.WVALID && wready && last_beat) next_state = RESP;
            end
            RESP: begin
                bvalid = 1'b1;
                if (axi.BREADY) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (ARESET) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bid_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            incr_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bresp_q <= 2'b00;
        end else if (aw_hs) begin
            bid_q  <= axi.AWID;
            addr_q <= axi.AWADDR & align_mask;
            len_q  <= axi.AWLEN;
            size_q <= axi.AWSIZE;
            incr_q <= (axi.AWBURST == 2'b01);
            cnt_q  <= '0;
            err_q  <= bad_aw;
        end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            if (incr_q) addr_q <= addr_q + step;
            if (wlast_bad) err_q <= 1'b1;
            if (last_beat) bresp_q <= (err_q | wlast_bad) ? 2'b10 : 2'b00;
        end
    end

    assign axi.AWREADY = awready;
    assign axi.WREADY  = wready;
    assign axi.BVALID  = bvalid;
    assign axi.BID     = bid_q;
    assign axi.BRESP   = bresp_q;

    assign mem_we    = beat & ~err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = axi.WDATA;
    assign mem_wstrb = axi.WSTRB;
endmodule

// File: tb/tb_asi_wr.sv
// Randomized scoreboard bench for asi_wr: bursts are modelled at issue time, a negedge monitor checks writes and responses.
module tb_asi_wr;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int LW = 8;
    localparam int SW = 3;
    localparam int BW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_wstrb;
    logic          mem_ready = 1'b0;

    asi_wr_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW)) axi ();

    asi_wr #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .axi       (axi),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] strb;
    } wr_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    wr_t wq[$];
    b_t  bq[$];

    int errors = 0;
    int checks = 0;
    int ready_mode = 2;   // 0 random, 1 toggle, 2 always ready
    int bready_mode = 0;  // 0 random, 1 hold low for five BVALID cycles
    int bhold = 0;
    bit in_data = 0;
    bit chk_wready = 0;
    int last_aw_wait = 0;
    int bvalid_len = 0;
    int last_bvalid_len = 0;
    bit b_prev_v = 0;
    logic [IW-1:0] b_prev_id;
    logic [1:0]    b_prev_resp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge ACLK) begin
        #1;
        case (ready_mode)
            0:       mem_ready = ($urandom_range(0, 3) != 0);
            1:       mem_ready = ~mem_ready;
            default: mem_ready = 1'b1;
        endcase
        if (bready_mode == 0) begin
            axi.BREADY = 1'($urandom_range(0, 1));
        end else begin
            if (axi.BVALID) bhold++;
            else bhold = 0;
            axi.BREADY = (bhold >= 6);
        end
    end

    always @(negedge ACLK) begin
        if (ARESET) begin
            b_prev_v = 0;
        end else begin
            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0h with no write expected", mem_addr);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data || mem_wstrb !== e.strb) begin
                        errors++;
                        $display("FAIL write: got addr %0h data %0h strb %0h expected addr %0h data %0h strb %0h",
                                 mem_addr, mem_wdata, mem_wstrb, e.addr, e.data, e.strb);
                    end
                end
            end
            if (axi.BVALID) begin
                checks++;
                if (b_prev_v) begin
                    bvalid_len++;
                    if (axi.BID !== b_prev_id || axi.BRESP !== b_prev_resp) begin
                        errors++;
                        $display("FAIL b_stable: got id %0h resp %0h expected id %0h resp %0h",
                                 axi.BID, axi.BRESP, b_prev_id, b_prev_resp);
                    end
                end else begin
                    bvalid_len = 1;
                    if (bq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_b: id %0h resp %0h with no response expected", axi.BID, axi.BRESP);
                    end else begin
                        b_t e;
                        e = bq.pop_front();
                        if (axi.BID !== e.id || axi.BRESP !== e.resp) begin
                            errors++;
                            $display("FAIL b_resp: got id %0h resp %0h expected id %0h resp %0h",
                                     axi.BID, axi.BRESP, e.id, e.resp);
                        end
                    end
                end
                last_bvalid_len = bvalid_len;
                checks++;
                if (axi.AWREADY !== 1'b0) begin
                    errors++;
                    $display("FAIL awready_during_b: got %0b expected 0", axi.AWREADY);
                end
            end
            if (chk_wready && in_data) begin
                checks++;
                if (axi.WREADY !== mem_ready) begin
                    errors++;
                    $display("FAIL wready_follow: got %0b expected %0b", axi.WREADY, mem_ready);
                end
            end
            b_prev_v    = axi.BVALID && !axi.BREADY;
            b_prev_id   = axi.BID;
            b_prev_resp = axi.BRESP;
        end
    end

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input logic [1:0] burst);
        int waited;
        axi.AWID    = id;
        axi.AWADDR  = addr;
        axi.AWLEN   = LW'(len);
        axi.AWSIZE  = SW'(size);
        axi.AWBURST = burst;
        axi.AWVALID = 1'b1;
        waited = 0;
        do begin
            @(negedge ACLK);
            waited++;
        end while (!axi.AWREADY);
        @(posedge ACLK);
        #1;
        axi.AWVALID  = 1'b0;
        in_data      = 1;
        last_aw_wait = waited;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [BW-1:0] s, input logic last);
        axi.WDATA  = d;
        axi.WSTRB  = s;
        axi.WLAST  = last;
        axi.WVALID = 1'b1;
        do @(negedge ACLK); while (!axi.WREADY);
        @(posedge ACLK);
        #1;
        axi.WVALID = 1'b0;
    endtask

    task automatic wait_b();
        do @(negedge ACLK); while (!(axi.BVALID && axi.BREADY));
        @(posedge ACLK);
        #1;
    endtask

    // Expected writes: aligned start, then +2^size per beat for INCR (mod 2^32), fixed for FIXED;
    // nothing after the first WLAST mismatch, nothing at all for a refused burst.
    task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len, input int size,
                            input logic [1:0] burst, input int early, input bit drop_last, input int aw_dly);
        logic [DW-1:0] data[$];
        logic [BW-1:0] strb[$];
        bit bad;
        int m;
        int w_dly;
        longint unsigned aligned;
        wr_t e;
        b_t  b;
        bad = burst[1] || (size > 4);
        m = -1;
        if (early >= 0 && early < len) m = early;
        else if (drop_last) m = len;
        aligned = longint'(addr) & ~((64'd1 << size) - 64'd1);
        for (int i = 0; i <= len; i++) begin
            logic [DW-1:0] d;
            logic [BW-1:0] s;
            d = {$urandom, $urandom, $urandom, $urandom};
            s = BW'($urandom);
            data.push_back(d);
            strb.push_back(s);
            if (!bad && (m < 0 || i <= m)) begin
                e.addr = (burst == 2'b01) ? AW'(aligned + longint'(i) * (64'd1 << size)) : AW'(aligned);
                e.data = d;
                e.strb = s;
                wq.push_back(e);
            end
        end
        b.id   = id;
        b.resp = (bad || m >= 0) ? 2'b10 : 2'b00;
        bq.push_back(b);
        w_dly = $urandom_range(0, 3);
        fork
            begin
                repeat (aw_dly) begin @(posedge ACLK); #1; end
                aw_send(id, addr, len, size, burst);
            end
            begin
                repeat (w_dly) begin @(posedge ACLK); #1; end
                for (int i = 0; i <= len; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge ACLK); #1; end
                    w_send(data[i], strb[i], (i == early) || (i == len && !drop_last));
                end
                in_data = 0;
            end
        join
        wait_b();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 128'(axi.AWREADY), 128'd0);
        chk({tag, "_wready"},  128'(axi.WREADY),  128'd0);
        chk({tag, "_bvalid"},  128'(axi.BVALID),  128'd0);
        chk({tag, "_bresp"},   128'(axi.BRESP),   128'd0);
        chk({tag, "_bid"},     128'(axi.BID),     128'd0);
        chk({tag, "_mem_we"},  128'(mem_we),      128'd0);
    endtask

    initial begin
        repeat (20000) @(posedge ACLK);
        errors++;
        $display("FAIL watchdog: got no completion within 20000 cycles, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_outputs("reset");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_after_reset", 128'(axi.AWREADY), 128'd1);
        @(posedge ACLK);
        #1;

        do_burst(8'h5A, 32'h0000_1004, 3, 4, 2'b01, -1, 0, 0);
        do_burst(8'h21, 32'h0000_0200, 2, 4, 2'b00, -1, 0, 3);
        do_burst(8'h33, 32'h0000_3000, 3, 4, 2'b10, -1, 0, 1);
        do_burst(8'h44, 32'h0000_4000, 3, 4, 2'b01, 1, 0, 0);
        do_burst(8'h50, 32'h0000_5007, 0, 0, 2'b01, -1, 0, 2);
        do_burst(8'h51, 32'h0000_5100, 0, 2, 2'b01, -1, 1, 0);
        do_burst(8'h52, 32'h0000_5200, 3, 3, 2'b01, -1, 1, 0);
        do_burst(8'h77, 32'hFFFF_FFF0, 2, 4, 2'b01, -1, 0, 0);
        do_burst(8'h78, 32'h0000_7000, 2, 5, 2'b01, -1, 0, 0);
        do_burst(8'h79, 32'h0000_7100, 1, 2, 2'b11, -1, 0, 0);
        ready_mode = 0;
        do_burst(8'hFF, 32'hFFFF_FF00, 255, 2, 2'b01, -1, 0, 1);

        ready_mode  = 1;
        bready_mode = 1;
        chk_wready  = 1;
        do_burst(8'h36, 32'h0000_6000, 7, 3, 2'b01, -1, 0, 0);
        chk_wready  = 0;
        bready_mode = 0;
        chk("bvalid_hold_cycles", 128'(last_bvalid_len), 128'd6);

        ready_mode = 2;
        begin
            wr_t e;
            logic [DW-1:0] d0, d1;
            logic [BW-1:0] s0, s1;
            d0 = {$urandom, $urandom, $urandom, $urandom};
            d1 = {$urandom, $urandom, $urandom, $urandom};
            s0 = BW'($urandom);
            s1 = BW'($urandom);
            e.addr = 32'h0000_8000; e.data = d0; e.strb = s0; wq.push_back(e);
            e.addr = 32'h0000_8010; e.data = d1; e.strb = s1; wq.push_back(e);
            aw_send(8'h99, 32'h0000_8000, 7, 4, 2'b01);
            w_send(d0, s0, 1'b0);
            w_send(d1, s1, 1'b0);
            ARESET  = 1'b1;
            in_data = 0;
            @(negedge ACLK);
            chk("mid_rst_awready", 128'(axi.AWREADY), 128'd0);
            chk("mid_rst_wready",  128'(axi.WREADY),  128'd0);
            chk("mid_rst_mem_we",  128'(mem_we),      128'd0);
            @(posedge ACLK);
            #1;
            @(negedge ACLK);
            chk_reset_outputs("mid_rst");
            chk("mid_rst_writes_done", 128'(wq.size()), 128'd0);
            @(posedge ACLK);
            #1;
            ARESET = 1'b0;
            do_burst(8'h9A, 32'h0000_9000, 1, 4, 2'b01, -1, 0, 0);
            chk("aw_wait_after_reset", 128'(last_aw_wait), 128'd1);
        end

        ready_mode = 0;
        for (int n = 0; n < 40; n++) begin
            int len, size, r, early;
            bit drop;
            logic [1:0] burst;
            len  = $urandom_range(0, 15);
            size = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 4);
            r = $urandom_range(0, 19);
            burst = (r < 12) ? 2'b01 : (r < 17) ? 2'b00 : (r < 19) ? 2'b10 : 2'b11;
            early = -1;
            drop  = 0;
            r = $urandom_range(0, 9);
            if (r == 0 && len > 0) early = $urandom_range(0, len - 1);
            else if (r == 1) drop = 1;
            do_burst(IW'($urandom), AW'($urandom), len, size, burst, early, drop, $urandom_range(0, 2));
        end

        repeat (3) @(posedge ACLK);
        chk("write_queue_drained", 128'(wq.size()), 128'd0);
        chk("b_queue_drained",     128'(bq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
